// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants for the hazard/stall unit: MIPS opcodes, FSM encoding,
// default load-use stall length and the "does ID read rt" decode.
package hazard_stall_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_RECOVER  = 2'd2;

  localparam int LU_STALL_CYCLES_DEFAULT = 1;

  // Loads and immediates only source rs; rt is their destination.
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != 16'hFFFF))
      count <= count + 16'd1;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// saturating event counters for both.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LU_STALL_CYCLES = LU_STALL_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  if_id_opcode,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic        ex_mem_branch,
  input  logic        ex_mem_zero,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

  logic [1:0] state, state_next;
  logic [1:0] lu_left, lu_left_next;
  logic       taken, hazard;

  assign taken  = ex_mem_branch & ex_mem_zero;
  assign hazard = id_ex_memread && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == if_id_rs) ||
                   (reads_rt(if_id_opcode) && (id_ex_rt == if_id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      lu_left <= 2'd0;
    end else begin
      state   <= state_next;
      lu_left <= lu_left_next;
    end
  end

  // Outputs are gated by rst_n so the pipeline free-runs while reset is held.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_next   = state;
    lu_left_next = lu_left;
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          if (taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = ST_RECOVER;
          end else if (hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_next   = ST_LU_STALL;
              lu_left_next = LU_RELOAD;
            end
          end
        end
        ST_LU_STALL: begin
          if (taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_next   = ST_RECOVER;
            lu_left_next = 2'd0;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            lu_left_next = lu_left - 2'd1;
            if (lu_left == 2'd1)
              state_next = ST_RUN;
          end
        end
        ST_RECOVER: begin
          // Load-use detection is masked for the cycle after a flush.
          if (taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next   = ST_RUN;
          lu_left_next = 2'd0;
        end
      endcase
    end
  end

  sat_counter16 u_stall_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (id_ex_bubble),
    .clear  (1'b0),
    .count  (stall_cnt)
  );

  sat_counter16 u_flush_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (if_id_flush),
    .clear  (1'b0),
    .count  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (1- and 3-cycle load-use stall)
// share inputs and are checked every cycle against a behavioural model.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opcode;
  logic [4:0] rs, rt, ex_rt;
  logic       memread, branch, zero;

  logic        pc_write_1, if_id_write_1, bubble_1, if_id_flush_1, id_ex_flush_1, ex_mem_flush_1;
  logic [15:0] stall_cnt_1, flush_cnt_1;
  logic        pc_write_3, if_id_write_3, bubble_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3;
  logic [15:0] stall_cnt_3, flush_cnt_3;

  hazard_stall_unit #(.LU_STALL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .if_id_opcode(opcode), .if_id_rs(rs), .if_id_rt(rt),
    .id_ex_memread(memread), .id_ex_rt(ex_rt), .ex_mem_branch(branch), .ex_mem_zero(zero),
    .pc_write(pc_write_1), .if_id_write(if_id_write_1), .id_ex_bubble(bubble_1),
    .if_id_flush(if_id_flush_1), .id_ex_flush(id_ex_flush_1), .ex_mem_flush(ex_mem_flush_1),
    .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
  );

  hazard_stall_unit #(.LU_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .if_id_opcode(opcode), .if_id_rs(rs), .if_id_rt(rt),
    .id_ex_memread(memread), .id_ex_rt(ex_rt), .ex_mem_branch(branch), .ex_mem_zero(zero),
    .pc_write(pc_write_3), .if_id_write(if_id_write_3), .id_ex_bubble(bubble_3),
    .if_id_flush(if_id_flush_3), .id_ex_flush(id_ex_flush_3), .ex_mem_flush(ex_mem_flush_3),
    .stall_cnt(stall_cnt_3), .flush_cnt(flush_cnt_3)
  );

  int total = 0;
  int bad   = 0;

  // Model state: extra stall cycles still owed, post-flush window, event counts.
  int lu_len[2] = '{1, 3};
  int rem[2]    = '{0, 0};
  bit rec[2]    = '{0, 0};
  int scnt[2]   = '{0, 0};
  int fcnt[2]   = '{0, 0};

  task automatic checkValue(input string tag, input logic [15:0] act, input logic [15:0] expv);
    total++;
    assert (act === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, act, expv);
    end
  endtask

  // Output vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush}
  task automatic checkOutput(input int k, input logic [5:0] act,
                             input logic [15:0] act_s, input logic [15:0] act_f);
    logic       taken, src_rt, haz;
    logic [5:0] expv;
    taken  = branch & zero;
    src_rt = (opcode == 6'b000000) || (opcode == 6'b101011) || (opcode == 6'b000100);
    haz    = memread && (ex_rt != 5'd0) && ((ex_rt == rs) || (src_rt && (ex_rt == rt)));
    expv   = 6'b110000;
    if (!rst_n) begin
      rem[k] = 0; rec[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
    checkValue($sformatf("lu%0d_stall_cnt", lu_len[k]), act_s, 16'(scnt[k]));
    checkValue($sformatf("lu%0d_flush_cnt", lu_len[k]), act_f, 16'(fcnt[k]));
    if (rst_n) begin
      if (taken) begin
        expv = 6'b110111;
        rem[k] = 0;
        rec[k] = 1'b1;
        if (fcnt[k] < 65535) fcnt[k]++;
      end else if (rem[k] > 0) begin
        expv = 6'b001000;
        rem[k]--;
        if (scnt[k] < 65535) scnt[k]++;
      end else if (rec[k]) begin
        rec[k] = 1'b0;
      end else if (haz) begin
        expv = 6'b001000;
        rem[k] = lu_len[k] - 1;
        if (scnt[k] < 65535) scnt[k]++;
      end
    end
    checkValue($sformatf("lu%0d_outputs", lu_len[k]), {10'd0, act}, {10'd0, expv});
  endtask

  task automatic applyStimulus(input logic rv, input logic [5:0] op, input logic [4:0] rsv,
                               input logic [4:0] rtv, input logic mr, input logic [4:0] exrt,
                               input logic br, input logic z);
    @(negedge clk);
    rst_n = rv; opcode = op; rs = rsv; rt = rtv;
    memread = mr; ex_rt = exrt; branch = br; zero = z;
    #1;
    checkOutput(0, {pc_write_1, if_id_write_1, bubble_1, if_id_flush_1, id_ex_flush_1, ex_mem_flush_1},
                stall_cnt_1, flush_cnt_1);
    checkOutput(1, {pc_write_3, if_id_write_3, bubble_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3},
                stall_cnt_3, flush_cnt_3);
  endtask

  initial begin
    logic [5:0] ops[4];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100};
    rst_n = 1'b0; opcode = '0; rs = '0; rt = '0; memread = 1'b0; ex_rt = '0; branch = 1'b0; zero = 1'b0;

    // Reset with hazard and branch inputs active: outputs must stay idle.
    applyStimulus(1'b0, 6'b000000, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    checkValue("reset_pc_write", {15'd0, pc_write_3}, 16'd1);
    checkValue("reset_flush", {15'd0, if_id_flush_3}, 16'd0);
    applyStimulus(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Single load-use stall on rt of an R-type.
    applyStimulus(1'b1, 6'b000000, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    checkValue("lu1_stall_pc_write", {15'd0, pc_write_1}, 16'd0);
    checkValue("lu1_stall_bubble", {15'd0, bubble_1}, 16'd1);
    applyStimulus(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    checkValue("lu1_after_stall_pc_write", {15'd0, pc_write_1}, 16'd1);
    checkValue("lu1_stall_cnt_one", stall_cnt_1, 16'd1);
    applyStimulus(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    checkValue("lu3_stall_cnt_three", stall_cnt_3, 16'd3);

    // Masked cases: rt=0 destination, and lw does not source its rt field.
    applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkValue("mask_rt0_bubble", {15'd0, bubble_1}, 16'd0);
    applyStimulus(1'b1, 6'b100011, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    checkValue("mask_lw_bubble", {15'd0, bubble_3}, 16'd0);

    // Multi-cycle stall with the hazard held for three cycles.
    applyStimulus(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'b101011, 5'd7, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0);
      checkValue($sformatf("lu3_multi_bubble%0d", i), {15'd0, bubble_3}, 16'd1);
    end
    applyStimulus(1'b1, 6'b101011, 5'd7, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0);
    checkValue("lu3_multi_done", {15'd0, bubble_3}, 16'd0);
    checkValue("lu3_multi_cnt", stall_cnt_3, 16'd3);

    // Taken branch in the second stall cycle aborts the stall.
    applyStimulus(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b000100, 5'd4, 5'd9, 1'b1, 5'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b000100, 5'd4, 5'd9, 1'b1, 5'd4, 1'b1, 1'b1);
    checkValue("abort_flush", {13'd0, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3}, 16'd7);
    checkValue("abort_pc_bubble", {14'd0, pc_write_3, bubble_3}, 16'd2);
    applyStimulus(1'b1, 6'b000100, 5'd4, 5'd9, 1'b1, 5'd4, 1'b0, 1'b1);
    checkValue("abort_recover_bubble", {15'd0, bubble_3}, 16'd0);
    checkValue("abort_flush_cnt", flush_cnt_3, 16'd1);
    applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset in the middle of a multi-cycle stall.
    applyStimulus(1'b1, 6'b000000, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0);
    applyStimulus(1'b0, 6'b000000, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0);
    checkValue("midreset_stall_cnt", stall_cnt_3, 16'd0);
    checkValue("midreset_bubble", {15'd0, bubble_3}, 16'd0);
    applyStimulus(1'b1, 6'b000000, 5'd8, 5'd1, 1'b0, 5'd8, 1'b0, 1'b0);
    checkValue("postreset_bubble", {15'd0, bubble_3}, 16'd0);

    // Random traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 4) == 4) ? 6'($urandom) : ops[$urandom_range(0, 3)],
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Flush counter saturation.
    applyStimulus(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++)
      applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkValue("sat_flush_cnt_lu1", flush_cnt_1, 16'hFFFF);
    checkValue("sat_flush_cnt_lu3", flush_cnt_3, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter LU_STALL_CYCLES, default 1, legal range 1..3: number of stall cycles per load-use hazard.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_id_opcode  input  6  opcode of the instruction in ID.
REQ-005 if_id_rs  input  5  rs field of the instruction in ID.
REQ-006 if_id_rt  input  5  rt field of the instruction in ID.
REQ-007 id_ex_memread  input  1  MemRead control of the instruction in EX.
REQ-008 id_ex_rt  input  5  destination rt of the instruction in EX.
REQ-009 ex_mem_branch  input  1  Branch control of the instruction in MEM.
REQ-010 ex_mem_zero  input  1  ALU zero flag of the instruction in MEM.
REQ-011 pc_write  output  1  PC update enable.
REQ-012 if_id_write  output  1  IF/ID register update enable.
REQ-013 id_ex_bubble  output  1  forces zero control bits into ID/EX.
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  clear the respective pipeline register.
REQ-015 stall_cnt  output  16  saturating count of load-use stall cycles.
REQ-016 flush_cnt  output  16  saturating count of taken branches.

Function
REQ-017 FSM states: RUN, LU_STALL, RECOVER.
REQ-018 Taken branch = ex_mem_branch & ex_mem_zero.
REQ-019 ID reads rt only for opcodes 000000 (R-type), 101011 (sw) and 000100 (beq); ID reads rs for all opcodes.
REQ-020 Load-use hazard = id_ex_memread=1, id_ex_rt!=0, and id_ex_rt equals if_id_rs, or equals if_id_rt when ID reads rt.
REQ-021 Outputs are combinational from state and inputs (Mealy). Idle values: pc_write=1, if_id_write=1, all other 1-bit outputs 0.
REQ-022 RUN with a taken branch: the three flushes are 1 and pc_write=1 in that cycle; next state RECOVER; flush_cnt increments.
REQ-023 RUN with a load-use hazard and no taken branch: pc_write=0, if_id_write=0, id_ex_bubble=1 in that cycle.
REQ-024 After REQ-023: if LU_STALL_CYCLES=1, next state is RUN; otherwise next state is LU_STALL and the stall counter is loaded with LU_STALL_CYCLES-1.
REQ-025 LU_STALL: the same stall outputs as REQ-023; the counter decrements each cycle; exit to RUN on the cycle the counter reaches 0.
REQ-026 Taken branch in LU_STALL: aborts the stall immediately with REQ-022 behaviour (stall outputs deasserted); next state RECOVER.
REQ-027 RECOVER lasts one cycle and load-use detection is masked. A taken branch in RECOVER gives REQ-022 behaviour and the state stays RECOVER; otherwise next state is RUN.
REQ-028 A taken branch has priority over a load-use hazard in every state.
REQ-029 stall_cnt increments once per cycle with id_ex_bubble=1.
REQ-030 stall_cnt and flush_cnt saturate at 16'hFFFF and never wrap.

Reset
REQ-031 rst_n=0 immediately forces: state RUN, stall counter 0, stall_cnt 0, flush_cnt 0.
REQ-032 While in reset, outputs take the RUN values of REQ-021 (pc_write=1, if_id_write=1, others 0) regardless of inputs.
REQ-033 Reset asserted during LU_STALL or RECOVER abandons that operation with no residual stall after release.

Structure
REQ-034 A shared package holds: opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100; the FSM state encoding; the LU_STALL_CYCLES default.
REQ-035 One sub-module, sat_counter16 (enable, clear, 16-bit saturating output), is instantiated twice, once for stall_cnt and once for flush_cnt.

Verification
REQ-036 Load-use stall: LU_STALL_CYCLES=1; id_ex_memread=1, id_ex_rt=5, ID opcode 000000 with rt=5 -> exactly one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1.
REQ-037 Masking cases: id_ex_rt=0, or ID opcode 100011 with rt=5 -> no stall.
REQ-038 Multi-cycle stall: LU_STALL_CYCLES=3 with a hazard held -> exactly 3 stall cycles, then RUN; stall_cnt=3.
REQ-039 Branch aborts stall: LU_STALL_CYCLES=3; taken branch in the 2nd stall cycle -> that cycle shows all flushes=1, pc_write=1, id_ex_bubble=0; next cycle no stall although the hazard inputs are still held; flush_cnt=1.
REQ-040 Reset and saturation: rst_n low mid-LU_STALL -> RUN with counters 0. Drive 65540 taken-branch cycles -> flush_cnt holds 16'hFFFF.
